kb_input_ctrl: RTL and testbench
================================

KB_INPUT_CTRL -- requirements
Module: kb_input_ctrl

Interface
REQ-001 Parameter: MAX_DIGITS, 8, maximum digits held per entry session (1..8).
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle pulse that opens an entry session.
REQ-005 abort  input  1  one-cycle pulse that cancels the current session.
REQ-006 dec_mode  input  1  radix for the session: 0 = hex, 1 = decimal; sampled only on an accepted start.
REQ-007 key_valid  input  1  one-cycle strobe, one per physical key press from the keypad scanner.
REQ-008 key_code  input  4  key value, qualified by key_valid; 0-D are digits, E is backspace, F is enter.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a converted value is on data.
REQ-011 data  output  32  converted value; holds until the next accepted start.
REQ-012 digits  output  4  current digit count of the session.
REQ-013 disp_buf  output  32  live digit buffer, newest digit in [3:0], for the seven-segment display.

Function
REQ-014 The block SHALL implement four states: IDLE, COLLECT, CONVERT, DONE.
REQ-015 IDLE: start SHALL move to COLLECT next cycle, clear disp_buf, digits and the accumulator, latch dec_mode, and clear data to 0.
REQ-016 start outside IDLE SHALL be ignored; key_valid in IDLE, CONVERT or DONE SHALL be ignored.
REQ-017 COLLECT, digit key accepted: disp_buf SHALL shift left 4 with key_code inserted at [3:0], and digits SHALL increment.
REQ-018 A digit key SHALL be accepted only when digits < MAX_DIGITS; otherwise it SHALL be dropped with no state change.
REQ-019 In decimal mode, codes A-D SHALL be dropped; in hex mode, codes 0-D SHALL be digits.
REQ-020 COLLECT, code E with digits > 0: disp_buf SHALL shift right 4 with zero fill, and digits SHALL decrement; code E with digits = 0 SHALL have no effect.
REQ-021 COLLECT, code F SHALL move to CONVERT and set acc = 0 and idx = digits.
REQ-022 CONVERT SHALL process one digit per cycle, oldest first: acc <= acc*base + disp_buf nibble[idx-1], then idx decrement; base is 10 or 16.
REQ-023 Multiply-accumulate SHALL be 32-bit modulo 2^32; 8 decimal digits cannot overflow.
REQ-024 CONVERT SHALL move to DONE when idx = 0; latency from F strobe to done SHALL be digits+2 cycles (F with 0 digits gives data = 0 after 2 cycles).
REQ-025 DONE SHALL assert done for exactly one cycle, drive data = acc, and return to IDLE next cycle.
REQ-026 abort in COLLECT or CONVERT SHALL return to IDLE next cycle, with no done and data unchanged at 0; abort in IDLE or DONE SHALL be ignored.
REQ-027 abort SHALL take priority over a key_valid in the same cycle.
REQ-028 disp_buf and digits SHALL hold their values through CONVERT, DONE and IDLE until the next accepted start.

Reset
REQ-029 On rst: state = IDLE; busy, done, data, digits, disp_buf, acc, idx and the latched mode SHALL all be 0.
REQ-030 rst asserted mid-session SHALL abandon the session immediately with no done pulse.

Verification
REQ-031 Hex session: start(dec_mode=0), keys 1,A,3,F -> done after 5 cycles, data = 0x0000_01A3, digits = 3.
REQ-032 Decimal session: start(dec_mode=1), keys 9,B,8,7,E,6,F -> B dropped, 7 erased, data = 986 (0x3DA).
REQ-033 Capacity: decimal mode, 10 presses of 9 then F -> digits = 8, data = 99,999,999 (0x05F5_E0FF).
REQ-034 Empty entry: start, E, F -> data = 0, done 2 cycles after F.
REQ-035 Abort and ignored start: start, keys 4,5, start, abort -> second start ignored, busy falls, no done, data = 0.
REQ-036 Reset mid-convert: 8 hex digits, F, rst at cycle 3 of CONVERT -> all outputs 0, no done pulse.

Source files
------------

// File: rtl/kb_input_ctrl.sv
// rtl/kb_input_ctrl.sv - keypad digit entry, edit and radix conversion controller
module kb_input_ctrl #(
  parameter int MAX_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        dec_mode,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic        busy,
  output logic        done,
  output logic [31:0] data,
  output logic [3:0]  digits,
  output logic [31:0] disp_buf
);

  typedef enum logic [1:0] {IDLE, COLLECT, CONVERT, DONE} state_t;

  localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

  state_t      state_q, state_d;
  logic [31:0] disp_q, disp_d;
  logic [3:0]  digits_q, digits_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  idx_q, idx_d;
  logic        dec_q, dec_d;
  logic [31:0] data_q, data_d;

  logic        is_digit;
  logic [3:0]  idx_m1;
  logic [3:0]  nib;
  logic [31:0] base;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      disp_q   <= '0;
      digits_q <= '0;
      acc_q    <= '0;
      idx_q    <= '0;
      dec_q    <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      disp_q   <= disp_d;
      digits_q <= digits_d;
      acc_q    <= acc_d;
      idx_q    <= idx_d;
      dec_q    <= dec_d;
      data_q   <= data_d;
    end
  end

  // Digits are converted oldest first: the oldest sits at nibble idx-1.
  assign is_digit = dec_q ? (key_code <= 4'd9) : (key_code <= 4'hD);
  assign idx_m1   = idx_q - 4'd1;
  assign nib      = 4'(disp_q >> {idx_m1, 2'b00});
  assign base     = dec_q ? 32'd10 : 32'd16;

  always_comb begin
    state_d  = state_q;
    disp_d   = disp_q;
    digits_d = digits_q;
    acc_d    = acc_q;
    idx_d    = idx_q;
    dec_d    = dec_q;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = COLLECT;
          disp_d   = '0;
          digits_d = '0;
          acc_d    = '0;
          idx_d    = '0;
          dec_d    = dec_mode;
          data_d   = '0;
        end
      end
      COLLECT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (key_valid) begin
          if (key_code == 4'hF) begin
            state_d = CONVERT;
            acc_d   = '0;
            idx_d   = digits_q;
          end else if (key_code == 4'hE) begin
            if (digits_q != 4'd0) begin
              disp_d   = {4'h0, disp_q[31:4]};
              digits_d = digits_q - 4'd1;
            end
          end else if (is_digit && (digits_q < MAX_D)) begin
            disp_d   = {disp_q[27:0], key_code};
            digits_d = digits_q + 4'd1;
          end
        end
      end
      CONVERT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (idx_q == 4'd0) begin
          state_d = DONE;
          data_d  = acc_q;
        end else begin
          acc_d = acc_q * base + {28'd0, nib};
          idx_d = idx_m1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign data     = data_q;
  assign digits   = digits_q;
  assign disp_buf = disp_q;

endmodule

// File: tb/tb_kb_input_ctrl.sv
// tb/tb_kb_input_ctrl.sv - scoreboard bench for kb_input_ctrl
module tb_kb_input_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        dec_mode = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'h0;
  logic        busy, done;
  logic [31:0] data, disp_buf;
  logic [3:0]  digits;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  digits;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   f_cyc = 0;

  kb_input_ctrl #(.MAX_DIGITS(8)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dec_mode(dec_mode),
    .key_valid(key_valid), .key_code(key_code), .busy(busy), .done(done),
    .data(data), .digits(digits), .disp_buf(disp_buf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got data 0x%08h expected no done", data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("done_data", data, e.data);
        chk("done_digits", {28'd0, digits}, {28'd0, e.digits});
        chk("done_latency", cyc - f_cyc, e.lat);
      end
    end
  end

  task automatic do_start(input logic m);
    start = 1'b1; dec_mode = m;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic press(input logic [3:0] c);
    if (c == 4'hF) f_cyc = cyc;
    key_valid = 1'b1; key_code = c;
    @(negedge clk);
    key_valid = 1'b0;
  endtask

  task automatic expect_done(input logic [31:0] d, input logic [3:0] n, input int lat);
    exp_t e;
    e.data = d; e.digits = n; e.lat = lat;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 40 && exp_q.size() != 0; t++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] s1[7] = '{4'h9, 4'hB, 4'h8, 4'h7, 4'hE, 4'h6, 4'hF};

    @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_data", data, 32'd0);
    chk("rst_digits", {28'd0, digits}, 32'd0);
    chk("rst_disp", disp_buf, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Hex session 1,A,3
    do_start(1'b0);
    chk("start_busy", {31'd0, busy}, 32'd1);
    press(4'h1); press(4'hA); press(4'h3);
    chk("hex_disp", disp_buf, 32'h0000_01A3);
    expect_done(32'h0000_01A3, 4'd3, 5);
    press(4'hF);
    wait_drain();
    chk("hex_idle_busy", {31'd0, busy}, 32'd0);
    chk("hex_disp_hold", disp_buf, 32'h0000_01A3);
    chk("hex_data_hold", data, 32'h0000_01A3);

    // Decimal with dropped B and backspace
    do_start(1'b1);
    expect_done(32'd986, 4'd3, 5);
    foreach (s1[i]) press(s1[i]);
    wait_drain();
    chk("dec_disp", disp_buf, 32'h0000_0986);

    // Capacity: ten 9s, two dropped
    do_start(1'b1);
    for (int i = 0; i < 10; i++) press(4'h9);
    chk("cap_digits", {28'd0, digits}, 32'd8);
    expect_done(32'd99999999, 4'd8, 10);
    press(4'hF);
    wait_drain();

    // Empty entry
    do_start(1'b0);
    press(4'hE);
    chk("empty_digits", {28'd0, digits}, 32'd0);
    expect_done(32'd0, 4'd0, 2);
    press(4'hF);
    wait_drain();

    // Full hex buffer of D
    do_start(1'b0);
    for (int i = 0; i < 8; i++) press(4'hD);
    expect_done(32'hDDDD_DDDD, 4'd8, 10);
    press(4'hF);
    wait_drain();

    // Abort, ignored start, abort beats a same-cycle key
    do_start(1'b0);
    chk("start_clears_data", data, 32'd0);
    press(4'h4); press(4'h5);
    do_start(1'b1);
    chk("ign_start_digits", {28'd0, digits}, 32'd2);
    abort = 1'b1; key_valid = 1'b1; key_code = 4'h7;
    @(negedge clk);
    abort = 1'b0; key_valid = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_disp", disp_buf, 32'h0000_0045);
    chk("abort_data", data, 32'd0);
    repeat (3) @(negedge clk);

    // Reset during CONVERT
    do_start(1'b0);
    for (int i = 1; i <= 8; i++) press(4'(i));
    press(4'hF);
    repeat (2) @(negedge clk);
    chk("conv_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_data", data, 32'd0);
    chk("mid_rst_digits", {28'd0, digits}, 32'd0);
    chk("mid_rst_disp", disp_buf, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
